rvfi_bus_responder: RTL and testbench

- Parametrised memory responder for the formal and simulation harness of the Veldt core; replaces the single free read-data register with a queued request/response model.
- Accepts fetch and data read requests and returns free-variable read data after a configurable latency, with optional stall injection.
- When enabled, substitutes a NOP for illegal or unsupported SYSTEM/CSR instruction words on fetch responses, so the core never executes them. This is a constructive filter, not a solver restriction.

---
 rtl/rvfi_bus_responder.sv | 180 ++++++++++++++++++
 tb/tb_rvfi_bus_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_bus_responder.sv
// rtl/rvfi_bus_responder.sv - queued fetch/data responder with latency, stall injection and CSR fetch filter
module rvfi_bus_responder #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 4,
  parameter int              LATENCY     = 1,
  parameter bit              ALLOW_STALL = 1'b1,
  parameter bit              CSR_FILTER  = 1'b1,
  parameter logic [XLEN-1:0] NOP_WORD    = XLEN'(32'h00000013)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_instr,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_rand_rdata,
  input  logic            i_rand_stall,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_instr,
  output logic [XLEN-1:0] o_rsp_addr,
  output logic            o_csr_filtered,
  output logic [15:0]     o_filter_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // The stored age is already one cycle ahead: an entry pushed with
  // LATENCY-1 reaches 0 exactly LATENCY cycles after its accept cycle.
  localparam int AW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] AGE_INIT = AW'(LATENCY - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic            r_q_instr [DEPTH];
  logic [XLEN-1:0] r_q_addr  [DEPTH];
  logic [AW-1:0]   r_q_age   [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_hold_rdata;
  logic            r_hold_filt;
  logic [15:0]     r_filter_count;

  logic            w_full;
  logic            w_eligible;
  logic            w_stall;
  logic            w_present_new;
  logic            w_rsp_valid;
  logic            w_cap_filt;
  logic [XLEN-1:0] w_cap_rdata;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // SYSTEM words the core must never see: non-CSRRS CSR ops, and CSRRS
  // unless it is a plain read (rs1=x0) of cycle/time/instret or their high halves.
  function automatic logic csr_illegal(input logic [6:0]  opcode,
                                       input logic [2:0]  funct3,
                                       input logic [4:0]  rs1,
                                       input logic [11:0] csr);
    logic r;
    r = 1'b0;
    if (opcode == 7'b1110011) begin
      case (funct3)
        3'b001, 3'b011, 3'b101, 3'b110, 3'b111: r = 1'b1;
        3'b010: r = !((csr inside {12'hC00, 12'hC01, 12'hC02,
                                   12'hC80, 12'hC81, 12'hC82}) && (rs1 == 5'd0));
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  assign w_full        = (r_count == FULL_CNT);
  assign w_eligible    = (r_count != '0) && (r_q_age[r_head] == '0);
  assign w_stall       = ALLOW_STALL && i_rand_stall;
  assign w_present_new = !i_reset && (r_state == S_IDLE) && w_eligible && !w_stall;
  assign w_rsp_valid   = !i_reset && ((r_state == S_HOLD) || w_present_new);
  assign w_cap_filt    = CSR_FILTER && r_q_instr[r_head] &&
                         csr_illegal(i_rand_rdata[6:0], i_rand_rdata[14:12],
                                     i_rand_rdata[19:15], i_rand_rdata[31:20]);
  assign w_cap_rdata   = w_cap_filt ? NOP_WORD : i_rand_rdata;
  assign w_push        = i_req_valid && o_req_ready;
  assign w_pop         = w_rsp_valid && i_rsp_ready;

  // Presentation state register: HOLD while a presented response waits for the core
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next state: enter HOLD on an unaccepted presentation, leave on acceptance
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_present_new && !i_rsp_ready) w_state_next = S_HOLD;
      S_HOLD:  if (i_rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs: live capture on the first presentation cycle, frozen copy while holding
  always_comb begin
    o_req_ready    = !i_reset && !w_full;
    o_rsp_valid    = w_rsp_valid;
    o_rsp_rdata    = '0;
    o_rsp_instr    = 1'b0;
    o_rsp_addr     = '0;
    o_csr_filtered = 1'b0;
    o_filter_count = i_reset ? 16'd0 : r_filter_count;
    if (w_rsp_valid) begin
      o_rsp_instr    = r_q_instr[r_head];
      o_rsp_addr     = r_q_addr[r_head];
      o_rsp_rdata    = (r_state == S_HOLD) ? r_hold_rdata : w_cap_rdata;
      o_csr_filtered = (r_state == S_HOLD) ? r_hold_filt  : w_cap_filt;
    end
  end

  // Request FIFO with per-entry ageing; pointers wrap at DEPTH
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= 1'b0;
        r_q_addr[i]  <= '0;
        r_q_age[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q_age[i] != '0) r_q_age[i] <= r_q_age[i] - 1'b1;
      end
      if (w_push) begin
        r_q_instr[r_tail] <= i_req_instr;
        r_q_addr[r_tail]  <= i_req_addr;
        r_q_age[r_tail]   <= AGE_INIT;
        r_tail            <= ptr_inc(r_tail);
      end
      if (w_pop) r_head <= ptr_inc(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Freeze the captured word and filter flag so the held response stays stable
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hold_rdata <= '0;
      r_hold_filt  <= 1'b0;
    end else if (w_present_new) begin
      r_hold_rdata <= w_cap_rdata;
      r_hold_filt  <= w_cap_filt;
    end
  end

  // Count substitutions once per presentation, saturating
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_filter_count <= 16'd0;
    end else if (w_present_new && w_cap_filt && (r_filter_count != 16'hFFFF)) begin
      r_filter_count <= r_filter_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_rvfi_bus_responder.sv
// tb/tb_rvfi_bus_responder.sv - scoreboard bench for rvfi_bus_responder
module tb_rvfi_bus_responder;

  localparam int          XLEN        = 32;
  localparam int          DEPTH       = 4;
  localparam int          LATENCY     = 1;
  localparam bit          ALLOW_STALL = 1'b1;
  localparam bit          CSR_FILTER  = 1'b1;
  localparam logic [31:0] NOP         = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_instr;
  logic [31:0] req_addr;
  logic [31:0] rand_rdata;
  logic        rand_stall;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_instr;
  logic [31:0] rsp_addr;
  logic        csr_filtered;
  logic [15:0] filter_count;

  rvfi_bus_responder #(
    .XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LATENCY),
    .ALLOW_STALL(ALLOW_STALL), .CSR_FILTER(CSR_FILTER), .NOP_WORD(NOP)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_instr(req_instr), .i_req_addr(req_addr),
    .i_rand_rdata(rand_rdata), .i_rand_stall(rand_stall),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_instr(rsp_instr), .o_rsp_addr(rsp_addr),
    .o_csr_filtered(csr_filtered), .o_filter_count(filter_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    int          acc;
  } req_t;

  req_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  bit          m_hold = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          m_filt = 1'b0;
  int          m_fcnt = 0;
  bit          post_rst = 1'b0;
  bit          exp_v;
  bit          exp_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ref_bad(input logic [31:0] w);
    if (w[6:0] != 7'h73) return 1'b0;
    if (w[14:12] == 3'd0 || w[14:12] == 3'd4) return 1'b0;
    if (w[14:12] != 3'd2) return 1'b1;
    return !((w[31:20] inside {12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82})
             && w[19:15] == 5'd0);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [11:0] csrs [6];
    csrs = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82};
    w = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      w[6:0] = 7'h73;
      if ($urandom_range(0, 1) == 1) w[14:12] = 3'd2;
      if ($urandom_range(0, 1) == 1) w[31:20] = csrs[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 1) w[19:15] = 5'd0;
    end
    return w;
  endfunction

  // Monitor: compares DUT outputs against the queued reference each cycle
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_req_ready", req_ready, 0);
      chk("reset_filter_count", filter_count, 0);
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_rsp_addr", rsp_addr, 0);
      chk("reset_rsp_instr", rsp_instr, 0);
      chk("reset_csr_filtered", csr_filtered, 0);
      sb.delete();
      m_hold   = 1'b0;
      m_fcnt   = 0;
      post_rst = 1'b1;
    end else begin
      exp_rdy = (sb.size() != DEPTH);
      chk("req_ready", req_ready, exp_rdy);
      chk("filter_count", filter_count, m_fcnt);
      exp_v = m_hold || (sb.size() > 0 && (cyc - sb[0].acc) >= LATENCY &&
                         !(ALLOW_STALL && rand_stall));
      chk("rsp_valid", rsp_valid, exp_v);
      if (post_rst && !exp_v) begin
        chk("post_reset_rsp_rdata", rsp_rdata, 0);
        chk("post_reset_rsp_addr", rsp_addr, 0);
      end
      post_rst = 1'b0;
      if (exp_v && rsp_valid) begin
        if (!m_hold) begin
          m_filt  = CSR_FILTER && sb[0].instr && ref_bad(rand_rdata);
          m_rdata = m_filt ? NOP : rand_rdata;
          if (m_filt && m_fcnt != 16'hFFFF) m_fcnt++;
        end
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_addr", rsp_addr, sb[0].addr);
        chk("rsp_instr", rsp_instr, sb[0].instr);
        chk("csr_filtered", csr_filtered, m_filt);
        if (rsp_ready) begin
          void'(sb.pop_front());
          m_hold = 1'b0;
        end else begin
          m_hold = 1'b1;
        end
      end
      if (req_valid && exp_rdy) sb.push_back(req_t'{req_instr, req_addr, cyc});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic one_req(input logic instr, input logic [31:0] addr);
    req_valid = 1'b1;
    req_instr = instr;
    req_addr  = addr;
    tick(1);
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_instr = 1'b0; req_addr = '0;
    rand_rdata = '0; rand_stall = 1'b0; rsp_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Single fetch, one-cycle latency
    rsp_ready  = 1'b1;
    rand_rdata = 32'h1234_5678;
    one_req(1'b1, 32'h100);
    tick(3);

    // Fill the queue with the core refusing responses, then pop once
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_instr  = i[0];
      req_addr   = 32'h200 + 32'(4 * i);
      rand_rdata = $urandom;
      tick(1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    tick(2);
    rsp_ready = 1'b1;
    tick(6);

    // CSR filter: permitted cycle read, then mstatus read
    rand_rdata = 32'hC000_2573;
    one_req(1'b1, 32'h300);
    tick(2);
    rand_rdata = 32'h3000_2573;
    one_req(1'b1, 32'h304);
    tick(2);

    // funct3=001 fetch is replaced, data read is not
    rand_rdata = 32'h0000_1073;
    one_req(1'b1, 32'h308);
    tick(2);
    one_req(1'b0, 32'h30C);
    tick(2);

    // Stall an eligible head for three cycles
    rand_stall = 1'b1;
    one_req(1'b1, 32'h400);
    tick(3);
    rand_stall = 1'b0;
    tick(2);

    // Hold with the core stalled while free inputs toggle
    rsp_ready = 1'b0;
    one_req(1'b1, 32'h500);
    for (int i = 0; i < 5; i++) begin
      rand_stall = $urandom_range(0, 1);
      rand_rdata = rand_word();
      tick(1);
    end
    rand_stall = 1'b0;
    rsp_ready  = 1'b1;
    tick(2);

    // Reset with three outstanding and a response presented
    rsp_ready = 1'b0;
    rand_rdata = 32'h3000_2573;
    one_req(1'b1, 32'h600);
    one_req(1'b0, 32'h604);
    one_req(1'b1, 32'h608);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid  = $urandom_range(0, 1);
      req_instr  = $urandom_range(0, 1);
      req_addr   = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      rand_rdata = rand_word();
      rand_stall = ($urandom_range(0, 9) < 3);
      rsp_ready  = $urandom_range(0, 1);
      rst        = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    rand_stall = 1'b0;
    tick(8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
